// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, parity-mode constants and
// the per-frame error flag bundle.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  typedef struct packed {
    logic parity_err;
    logic frame_err;
  } rx_flags_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus a tick-qualified
// falling-edge detect.
// Ports: CLK, RST (sync, active-high), sample_tick, ser_in (async line),
//        ser_sync (synchronized line), fall_c (high when the line was high at
//        the previous sample_tick and is low now).
module uart_rx_sync (
  input  logic CLK,
  input  logic RST,
  input  logic sample_tick,
  input  logic ser_in,
  output logic ser_sync,
  output logic fall_c
);

  logic       meta;
  logic [1:0] fill;
  logic       prev;
  logic       prev_vld;

  // The 1s loaded at reset are not line data; fill tracks when the flops
  // hold real samples so a line that is already low never looks like an edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      meta     <= 1'b1;
      ser_sync <= 1'b1;
      fill     <= 2'b00;
      prev     <= 1'b1;
      prev_vld <= 1'b0;
    end else begin
      meta     <= ser_in;
      ser_sync <= meta;
      fill     <= {fill[0], 1'b1};
      if (sample_tick && fill[1]) begin
        prev     <= ser_sync;
        prev_vld <= 1'b1;
      end
    end
  end

  assign fall_c = prev_vld & prev & ~ser_sync;

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with a one-word output holding register.
// Ports: CLK, RST (sync, active-high), sample_tick (baud*OVERSAMPLE strobe),
//        ser_in (async line, idle high), rx_data/rx_valid/rx_ready (held word
//        handshake), parity_err/frame_err (flags of held word), overrun
//        (one-CLK pulse when a completed frame is dropped), busy (not IDLE).
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned PARITY_MODE = 0,
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 sample_tick,
  input  logic                 ser_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam bit            HAS_PAR   = (PARITY_MODE != PAR_NONE);
  localparam bit            ODD_PAR   = (PARITY_MODE == PAR_ODD);

  logic                 ser_sync;
  logic                 fall_c;
  uart_state_e          state;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  rx_flags_t            flags_acc;
  rx_flags_t            flags_cap;
  logic                 commit_q;
  logic                 mid_bit;

  uart_rx_sync u_sync (
    .CLK         (CLK),
    .RST         (RST),
    .sample_tick (sample_tick),
    .ser_in      (ser_in),
    .ser_sync    (ser_sync),
    .fall_c      (fall_c)
  );

  assign mid_bit = (tick_cnt == TICK_LAST);

  // Frame FSM; everything advances only on sample_tick.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      flags_acc <= '0;
      flags_cap <= '0;
      commit_q  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      commit_q <= 1'b0;
      if (sample_tick) begin
        case (state)
          ST_IDLE: begin
            if (fall_c) begin
              state    <= ST_START;
              tick_cnt <= '0;
              busy     <= 1'b1;
            end
          end
          ST_START: begin
            if (tick_cnt == TICK_HALF) begin
              tick_cnt <= '0;
              if (ser_sync) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end else begin
                state     <= ST_DATA;
                bit_cnt   <= '0;
                flags_acc <= '0;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          ST_DATA: begin
            if (mid_bit) begin
              tick_cnt <= '0;
              shreg    <= {ser_sync, shreg[DATA_BITS-1:1]};
              if (bit_cnt == DATA_LAST) begin
                bit_cnt <= '0;
                state   <= HAS_PAR ? ST_PARITY : ST_STOP;
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          ST_PARITY: begin
            if (mid_bit) begin
              tick_cnt             <= '0;
              flags_acc.parity_err <= (((^shreg) ^ ser_sync) != ODD_PAR);
              state                <= ST_STOP;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          ST_STOP: begin
            if (mid_bit) begin
              tick_cnt <= '0;
              if (bit_cnt == STOP_LAST) begin
                bit_cnt              <= '0;
                flags_cap.parity_err <= flags_acc.parity_err;
                flags_cap.frame_err  <= flags_acc.frame_err | ~ser_sync;
                commit_q             <= 1'b1;
                state                <= ST_IDLE;
                busy                 <= 1'b0;
              end else begin
                bit_cnt             <= bit_cnt + BW'(1);
                flags_acc.frame_err <= flags_acc.frame_err | ~ser_sync;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Output holding register; shreg is stable until the next frame's data
  // phase, which is at least half a bit after commit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (commit_q) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shreg;
          parity_err <= flags_cap.parity_err;
          frame_err  <= flags_cap.frame_err;
          rx_valid   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: three instances (8N1, 8E1, 8N2) each fed
// by a line driver; a monitor per instance checks every accepted word.
module tb_uart_rx_os;

  localparam int unsigned PMODE [3] = '{0, 1, 0};
  localparam int unsigned NSTOP [3] = '{1, 1, 2};

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic            tick = 1'b1;
  logic [2:0]      ser = 3'b111;
  logic [2:0]      rdy = 3'b111;
  logic [2:0][7:0] rxd;
  logic [2:0]      vld, pe, fe, ovr, busy;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   tick_div = 1;
  int   ph = 0;
  int   ovr_cnt [3] = '{0, 0, 0};
  exp_t sbq [3][$];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    uart_rx_os #(
      .DATA_BITS   (8),
      .OVERSAMPLE  (16),
      .PARITY_MODE (PMODE[k]),
      .STOP_BITS   (NSTOP[k])
    ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .sample_tick (tick),
      .ser_in      (ser[k]),
      .rx_data     (rxd[k]),
      .rx_valid    (vld[k]),
      .rx_ready    (rdy[k]),
      .parity_err  (pe[k]),
      .frame_err   (fe[k]),
      .overrun     (ovr[k]),
      .busy        (busy[k])
    );
  end

  task automatic check(input string name, input int k, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s[%0d] got %0h expected %0h at cycle %0d", name, k, got, exp, cyc);
    end
  endtask

  // Monitors: compare each word on the cycle it is accepted.
  for (genvar k = 0; k < 3; k++) begin : g_mon
    exp_t e;
    always @(negedge CLK) begin
      if (!RST) begin
        if (ovr[k]) ovr_cnt[k]++;
        if (vld[k] && rdy[k]) begin
          if (sbq[k].size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_word[%0d] got %0h expected none", k, rxd[k]);
          end else begin
            e = sbq[k].pop_front();
            check("rx_data", k, int'(rxd[k]), int'(e.d));
            check("parity_err", k, int'(pe[k]), int'(e.pe));
            check("frame_err", k, int'(fe[k]), int'(e.fe));
          end
        end
      end
    end
  end

  // sample_tick generator: one strobe every tick_div cycles.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      ph   = (ph + 1 >= tick_div) ? 0 : ph + 1;
      tick = (ph == 0);
    end
  end

  initial begin
    repeat (90000) @(posedge CLK);
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic drive_bit(input int k, input logic b);
    ser[k] = b;
    repeat (16 * tick_div) @(posedge CLK);
    #1;
  endtask

  // Reference model: expected word is the sent payload; parity error iff the
  // sent parity bit was deliberately wrong; frame error iff any stop bit low.
  task automatic send_frame(input int k, input logic [7:0] d, input bit bad_par,
                            input logic [1:0] stop_low, input bit push);
    exp_t e;
    logic p;
    if (push) begin
      e.d  = d;
      e.pe = (PMODE[k] != 0) && bad_par;
      e.fe = (NSTOP[k] == 2) ? (stop_low != 2'b00) : stop_low[0];
      sbq[k].push_back(e);
    end
    drive_bit(k, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(k, d[i]);
    if (PMODE[k] != 0) begin
      p = (^d) ^ (PMODE[k] == 2) ^ bad_par;
      drive_bit(k, p);
    end
    for (int s = 0; s < int'(NSTOP[k]); s++) drive_bit(k, ~stop_low[s]);
    ser[k] = 1'b1;
  endtask

  task automatic idle(input int n);
    if (n > 0) begin
      repeat (n) @(posedge CLK);
      #1;
    end
  endtask

  task automatic check_all_zero(input string name);
    for (int k = 0; k < 3; k++)
      check(name, k, int'({rxd[k], vld[k], pe[k], fe[k], ovr[k], busy[k]}), 0);
  endtask

  initial begin
    int t_fall, t_rise, gap;
    bit seen_busy;
    logic [7:0] d;
    logic [1:0] sl;
    bit bad;

    repeat (4) @(posedge CLK);
    #1;
    check_all_zero("reset_state");
    RST = 1'b0;
    idle(40);

    // 8N1 0xA5: word plus commit one CLK after the final stop sample
    t_fall = -1;
    t_rise = -1;
    seen_busy = 1'b0;
    fork
      send_frame(0, 8'hA5, 1'b0, 2'b00, 1'b1);
      begin
        for (int c = 0; c < 400 && t_rise < 0; c++) begin
          @(negedge CLK);
          if (busy[0]) seen_busy = 1'b1;
          else if (seen_busy && t_fall < 0) t_fall = cyc;
          if (vld[0] && t_rise < 0) t_rise = cyc;
        end
        check("commit_latency", 0, t_rise - t_fall, 1);
      end
    join
    idle(20);

    // 8E1 parity: wrong then right parity bit
    send_frame(1, 8'h3C, 1'b1, 2'b00, 1'b1);
    idle(20);
    send_frame(1, 8'h3C, 1'b0, 2'b00, 1'b1);
    idle(20);

    // 8N2 with second stop low; line then returns high before next frame
    send_frame(2, 8'h55, 1'b0, 2'b10, 1'b1);
    idle(24);
    send_frame(2, 8'hC3, 1'b0, 2'b00, 1'b1);
    idle(20);

    // Overrun: hold 0x11, drop 0x22, then ready exactly on 0x33's commit
    rdy[0] = 1'b0;
    send_frame(0, 8'h11, 1'b0, 2'b00, 1'b1);
    idle(20);
    send_frame(0, 8'h22, 1'b0, 2'b00, 1'b0);
    idle(20);
    check("overrun_count", 0, ovr_cnt[0], 1);
    check("held_valid", 0, int'(vld[0]), 1);
    fork
      send_frame(0, 8'h33, 1'b0, 2'b00, 1'b1);
      begin
        for (int c = 0; c < 400; c++) begin
          @(posedge CLK);
          #1;
          if (busy[0]) break;
        end
        for (int c = 0; c < 400; c++) begin
          @(posedge CLK);
          #1;
          if (!busy[0]) break;
        end
        rdy[0] = 1'b1;
      end
    join
    idle(20);
    check("overrun_after_handshake", 0, ovr_cnt[0], 1);

    // Short low glitch on idle line is rejected
    ser[0] = 1'b0;
    idle(4);
    ser[0] = 1'b1;
    idle(60);
    check("glitch_busy", 0, int'(busy[0]), 0);
    check("glitch_valid", 0, int'(vld[0]), 0);

    // Reset in the middle of the data phase
    drive_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, 1'b0);
    check("busy_mid_data", 0, int'(busy[0]), 1);
    RST = 1'b1;
    ser[0] = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check_all_zero("mid_frame_reset");
    @(posedge CLK);
    #1;
    RST = 1'b0;
    idle(40);
    send_frame(0, 8'h5A, 1'b0, 2'b00, 1'b1);
    idle(20);

    // Randomized frames on every instance, tick every 1 or 2 CLKs
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 10; n++) begin
        tick_div = $urandom_range(1, 2);
        idle(4);
        d   = 8'($urandom);
        bad = (PMODE[k] != 0) && ($urandom_range(0, 3) == 0);
        sl  = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        if (NSTOP[k] == 1) sl[1] = 1'b0;
        send_frame(k, d, bad, sl, 1'b1);
        gap = $urandom_range(0, 30);
        if (sl[NSTOP[k]-1]) gap += 16 * tick_div;
        idle(gap);
      end
      idle(40);
    end
    tick_div = 1;
    idle(40);

    for (int k = 0; k < 3; k++) begin
      check("scoreboard_empty", k, sbq[k].size(), 0);
      check("final_busy", k, int'(busy[k]), 0);
    end
    check("overrun_final", 0, ovr_cnt[0], 1);
    check("overrun_final", 1, ovr_cnt[1], 0);
    check("overrun_final", 2, ovr_cnt[2], 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 Parameter DATA_BITS, default 8, payload bits per frame; legal range 5..9.
REQ-002 Parameter OVERSAMPLE, default 16, sample_tick strobes per bit; even, legal range 8..32.
REQ-003 Parameter PARITY_MODE, default 0, parity selection: 0 none, 1 even, 2 odd.
REQ-004 Parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-005 CLK  input  1  system clock; all logic on rising edge.
REQ-006 RST  input  1  reset, synchronous, active-high.
REQ-007 sample_tick  input  1  one-CLK strobe at baud*OVERSAMPLE rate.
REQ-008 ser_in  input  1  asynchronous serial line; idle high.
REQ-009 rx_data  output  DATA_BITS  received word, LSB = first bit on line.
REQ-010 rx_valid  output  1  rx_data and error flags valid.
REQ-011 rx_ready  input  1  consumer accepts word when rx_valid && rx_ready.
REQ-012 parity_err  output  1  parity mismatch on held word; 0 when PARITY_MODE=0.
REQ-013 frame_err  output  1  any stop bit sampled low on held word.
REQ-014 overrun  output  1  one-CLK pulse: completed frame dropped.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 ser_in SHALL pass through a 2-flop synchronizer; all sampling uses the synchronized value.
REQ-017 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; tick counter width clog2(OVERSAMPLE); bit counter width clog2(DATA_BITS+1).
REQ-018 IDLE -> START on synchronized high-to-low transition; a line that is already low on leaving reset or STOP SHALL NOT start a frame until it returns high.
REQ-019 START: after OVERSAMPLE/2 ticks, resample; high -> IDLE (glitch rejected, no output); low -> DATA with tick counter cleared.
REQ-020 DATA: sample one bit every OVERSAMPLE ticks (mid-bit), shift LSB first; after DATA_BITS samples -> PARITY if PARITY_MODE!=0, else STOP.
REQ-021 PARITY: sample one bit after OVERSAMPLE ticks; error if XOR(data, parity bit) != (PARITY_MODE==2).
REQ-022 STOP: sample STOP_BITS bits, OVERSAMPLE ticks apart; any low sample sets the frame error for this frame; after the last sample -> IDLE.
REQ-023 Frame commit: on the CLK after the last stop sample, rx_data, parity_err and frame_err SHALL load and rx_valid SHALL rise; erroneous frames are still delivered with their flag set.
REQ-024 rx_valid, rx_data and the error flags SHALL hold stable until the cycle rx_valid && rx_ready; rx_valid falls on the next edge.
REQ-025 Commit while rx_valid=1 and rx_ready=0: new frame dropped, held word kept, overrun pulses high for exactly one CLK.
REQ-026 Commit in the same cycle as an accepting handshake: new word loaded, rx_valid stays high, no overrun.
REQ-027 Counters SHALL advance only on cycles with sample_tick=1; FSM state is frozen between ticks.
REQ-028 rx_ready SHALL have no combinational path to any output.

Reset
REQ-029 RST SHALL return the FSM to IDLE and clear both counters, the shift register and the synchronizer (load 1s).
REQ-030 During reset, rx_data=0, rx_valid=0, parity_err=0, frame_err=0, overrun=0 and busy=0; a frame in progress is discarded with no commit.

Structure
REQ-031 Package uart_pkg SHALL hold the FSM state encoding and the PARITY_MODE constants (PAR_NONE, PAR_EVEN, PAR_ODD), shared with the transmitter.
REQ-032 Sub-module uart_rx_sync SHALL hold the 2-flop synchronizer and falling-edge detect; all other logic lives in uart_rx_os.

Verification (OVERSAMPLE=16, sample_tick every CLK unless stated)
REQ-033 8N1, send 0xA5, rx_ready=1 -> rx_valid pulse with rx_data=0xA5, no error flags, first rise 1 CLK after the final stop sample.
REQ-034 8E1, send 0x3C with parity bit 1 (wrong) -> rx_data=0x3C, parity_err=1; repeat with parity bit 0 -> parity_err=0.
REQ-035 8N2, send 0x55 with the second stop bit driven low -> rx_data=0x55, frame_err=1; FSM waits for line high before the next frame.
REQ-036 rx_ready=0, send 0x11 then 0x22 -> rx_data holds 0x11, overrun pulses once; then assert rx_ready exactly on 0x33's commit cycle -> 0x33 loaded, no overrun.
REQ-037 Low glitch of 4 ticks on an idle line -> FSM returns to IDLE, no rx_valid; RST asserted mid-DATA -> all outputs 0 next CLK, and a following clean frame is received correctly.
